// File: rtl/uart_tx_ctrl_pkg.sv
// Shared encodings for the UART transmit path: FSM states, parity select
// values and line levels.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    localparam logic IDLE_BIT  = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte request, serializer link and line outputs of the UART TX controller.
// The controller is the slave; the host/serializer side is the master.
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  ser_data;
    logic                  ser_done;
    logic                  ser_en;
    logic [DATA_WIDTH-1:0] ser_p_data;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_data, ser_done,
        input  ser_en, ser_p_data, TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_data, ser_done,
        output ser_en, ser_p_data, TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx_ctrl_parity_calc.sv
// Combinational parity generator over a data word; even = XOR-reduce,
// odd = inverted XOR-reduce. Shared with the RX checker.
module parity_calc
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    output logic                  par_bit_o
);

    always_comb begin
        par_bit_o = ^data_i;
        if (par_typ_i == PAR_ODD) begin
            par_bit_o = ~(^data_i);
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX controller: latches a byte and frame options, sequences the
// serializer and drives a registered start/data/parity/stop line with Busy.
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic           CLK,
    input  logic           rst,
    uart_tx_ctrl_if.slave  bus
);

    localparam int                CNT_W   = $clog2(DATA_WIDTH + 2);
    localparam logic [CNT_W-1:0]  WD_LAST = CNT_W'(DATA_WIDTH);

    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  par_bit;

    parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data_i    (data_q),
        .par_typ_i (par_typ_q),
        .par_bit_o (par_bit)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.Data_Valid) begin
                    data_d    = bus.P_DATA;
                    par_en_d  = bus.PAR_EN;
                    par_typ_d = bus.PAR_TYP;
                    state_d   = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = DATA;
            end
            DATA: begin
                // Watchdog: one grace cycle past the nominal data length, then
                // abandon the frame so the line cannot hang low.
                if (bus.ser_done) begin
                    state_d = par_en_q ? PARITY : STOP;
                end else if (cnt_q == WD_LAST) begin
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PARITY: state_d = STOP;
            STOP: begin
                if (bus.Data_Valid) begin
                    data_d    = bus.P_DATA;
                    par_en_d  = bus.PAR_EN;
                    par_typ_d = bus.PAR_TYP;
                    state_d   = START;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line mux follows the current state; the flop adds one cycle of lag.
    always_comb begin
        tx_d = IDLE_BIT;
        case (state_q)
            START:   tx_d = START_BIT;
            DATA:    tx_d = bus.ser_data;
            PARITY:  tx_d = par_bit;
            STOP:    tx_d = STOP_BIT;
            default: tx_d = IDLE_BIT;
        endcase
        busy_d = (state_q != IDLE);
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            cnt_q     <= '0;
            tx_q      <= IDLE_BIT;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            cnt_q     <= cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.ser_en     = (state_q == START) || (state_q == DATA);
    assign bus.ser_p_data = data_q;
    assign bus.TX_OUT     = tx_q;
    assign bus.Busy       = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl with a behavioural LSB-first serializer.
module tb_uart_tx_ctrl;

    localparam int DW = 8;

    logic CLK = 1'b0;
    logic rst = 1'b0;
    always #5 CLK = ~CLK;

    uart_tx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural serializer: loads on the START edge, shifts one bit per DATA
    // cycle, flags the last bit; withhold suppresses ser_done.
    logic [DW-1:0] sm_sh;
    logic [4:0]    sm_cnt;
    logic          sm_act;
    logic          withhold = 1'b0;

    always @(posedge CLK or negedge rst) begin
        if (!rst) begin
            sm_sh  <= '0;
            sm_cnt <= '0;
            sm_act <= 1'b0;
        end else if (bus.ser_en && !sm_act) begin
            sm_sh  <= bus.ser_p_data;
            sm_cnt <= '0;
            sm_act <= 1'b1;
        end else if (bus.ser_en) begin
            if (sm_cnt == 5'(DW - 1) && !withhold) begin
                sm_act <= 1'b0;
            end else begin
                sm_sh  <= sm_sh >> 1;
                sm_cnt <= sm_cnt + 5'd1;
            end
        end else begin
            sm_act <= 1'b0;
        end
    end

    assign bus.ser_data = sm_sh[0];
    assign bus.ser_done = sm_act && (sm_cnt == 5'(DW - 1)) && !withhold;

    logic exp_q[$];
    logic mon_en   = 1'b0;
    int   run      = 0;
    int   last_run = 0;
    bit   run_done = 1'b0;
    int   sen_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
        if (pe) exp_q.push_back(pt ? ~(^d) : ^d);
        exp_q.push_back(1'b1);
    endtask

    // Monitor: every Busy cycle consumes one expected line bit; idle cycles
    // must show a high line.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (bus.ser_en) sen_cnt++;
            if (bus.Busy) begin
                logic e;
                run++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
                chk("line_bit", {31'd0, bus.TX_OUT}, {31'd0, e});
            end else begin
                if (run > 0) begin
                    last_run = run;
                    run_done = 1'b1;
                    run      = 0;
                end
                chk("idle_line", {31'd0, bus.TX_OUT}, 32'd1);
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt, input bit do_push);
        @(negedge CLK);
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.Data_Valid = 1'b1;
        if (do_push) push_frame(d, pe, pt);
        @(negedge CLK);
        bus.Data_Valid = 1'b0;
        @(negedge CLK);
        chk("start_latency", {30'd0, bus.Busy, bus.TX_OUT}, 32'b10);
    endtask

    task automatic wait_frame(input string name, input int exp_run, input int exp_sen);
        int k = 0;
        while (!run_done && k < 100) begin
            @(negedge CLK);
            k++;
        end
        if (!run_done) begin
            chk({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({name, "_busy_len"}, last_run, exp_run);
            chk({name, "_ser_en_len"}, sen_cnt, exp_sen);
            chk({name, "_queue_left"}, exp_q.size(), 32'd0);
        end
        run_done = 1'b0;
        sen_cnt  = 0;
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        bus.P_DATA     = '0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.Data_Valid = 1'b0;

        #12;
        chk("rst_tx", {31'd0, bus.TX_OUT}, 32'd1);
        chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("rst_ser_en", {31'd0, bus.ser_en}, 32'd0);
        chk("rst_p_data", {24'd0, bus.ser_p_data}, 32'd0);
        @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);
        mon_en = 1'b1;
        repeat (2) @(negedge CLK);

        send(8'hA5, 1'b0, 1'b0, 1'b1);
        wait_frame("a5_nopar", 10, 9);

        send(8'hA5, 1'b1, 1'b0, 1'b1);
        wait_frame("a5_even", 11, 9);

        send(8'hA5, 1'b1, 1'b1, 1'b1);
        wait_frame("a5_odd", 11, 9);

        send(8'h07, 1'b1, 1'b0, 1'b1);
        @(negedge CLK);
        bus.P_DATA = 8'hFF;
        wait_frame("07_even_toggle", 11, 9);

        // Data_Valid pulse mid-DATA must not start or queue a frame.
        send(8'h5A, 1'b0, 1'b0, 1'b1);
        @(negedge CLK);
        bus.P_DATA     = 8'h55;
        bus.Data_Valid = 1'b1;
        @(negedge CLK);
        bus.Data_Valid = 1'b0;
        wait_frame("pulse_ignored", 10, 9);

        // Back-to-back: second byte accepted in the first frame's STOP cycle.
        @(negedge CLK);
        bus.P_DATA     = 8'h3C;
        bus.PAR_EN     = 1'b0;
        bus.Data_Valid = 1'b1;
        push_frame(8'h3C, 1'b0, 1'b0);
        push_frame(8'hC3, 1'b0, 1'b0);
        @(negedge CLK);
        bus.P_DATA = 8'hC3;
        repeat (11) @(negedge CLK);
        bus.Data_Valid = 1'b0;
        wait_frame("back_to_back", 20, 18);

        // Missing ser_done: 9 DATA cycles (last one shifts in a 0), forced STOP.
        withhold = 1'b1;
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        send(8'hFF, 1'b0, 1'b0, 1'b0);
        wait_frame("watchdog", 11, 10);
        withhold = 1'b0;

        // Asynchronous reset in the middle of DATA.
        send(8'hA5, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge CLK);
        #2;
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        chk("midrst_tx", {31'd0, bus.TX_OUT}, 32'd1);
        chk("midrst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("midrst_ser_en", {31'd0, bus.ser_en}, 32'd0);
        exp_q.delete();
        run      = 0;
        run_done = 1'b0;
        sen_cnt  = 0;
        @(negedge CLK);
        rst = 1'b1;
        @(negedge CLK);
        mon_en = 1'b1;

        send(8'h3C, 1'b1, 1'b1, 1'b1);
        wait_frame("post_reset_odd", 11, 9);

        chk("final_queue", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
